// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, digit type, sequencer states and the
// nines-complement helper used for subtraction.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic digit_t nines_comp(input digit_t d);
        return digit_t'(4'd9 - d);
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One decimal digit of addition: digit = (a + b + cin) mod 10, cout on overflow.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  digit_t a,
    input  digit_t b,
    input  logic   cin,
    output digit_t digit,
    output logic   cout
);

    logic [4:0] t;

    always_comb begin
        t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (t > 5'd9) begin
            digit = digit_t'(t - 5'd10);
            cout  = 1'b1;
        end else begin
            digit = t[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor, one digit per cycle, LSD first.
// Optional non-BCD input detection is compiled in with BCD_INVALID_DETECT_EN.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          sub,
    input  logic                          cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout,
    output logic                          invalid
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_t           state, state_nxt;
    logic [W-1:0]     a_sh, b_sh, sum_r;
    logic             sub_r, carry, cout_r;
    logic [IDX_W-1:0] idx;
    logic             accept, last_digit;
    digit_t           b_dig, step_dig;
    logic             step_c;

    assign in_ready   = (state == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign last_digit = (state == BUSY) && (idx == LAST);
    assign out_valid  = (state == DONE);
    assign sum        = sum_r;
    assign cout       = cout_r;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = BUSY;
            BUSY:    if (last_digit) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Operands shift right so the current digit always sits in the low nibble.
    assign b_dig = sub_r ? nines_comp(b_sh[BCD_DIGIT_W-1:0]) : b_sh[BCD_DIGIT_W-1:0];

    bcd_digit_step u_step (
        .a     (a_sh[BCD_DIGIT_W-1:0]),
        .b     (b_dig),
        .cin   (carry),
        .digit (step_dig),
        .cout  (step_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            sub_r  <= 1'b0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_r  <= '0;
            sub_r  <= sub;
            // Subtraction is a + nines(b) + !borrow, giving ten's complement.
            carry  <= sub ? ~cin : cin;
            cout_r <= 1'b0;
            idx    <= '0;
        end else if (state == BUSY) begin
            a_sh  <= a_sh >> BCD_DIGIT_W;
            b_sh  <= b_sh >> BCD_DIGIT_W;
            carry <= step_c;
            sum_r[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= step_dig;
            idx   <= idx + 1'b1;
            if (idx == LAST) cout_r <= step_c;
        end
    end

`ifdef BCD_INVALID_DETECT_EN
    logic inv_pend, invalid_r;

    function automatic logic any_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_pend  <= 1'b0;
            invalid_r <= 1'b0;
        end else if (accept) begin
            inv_pend  <= any_bad(a) || any_bad(b);
            invalid_r <= 1'b0;
        end else if (last_digit) begin
            invalid_r <= inv_pend;
        end
    end

    assign invalid = invalid_r;
`else
    assign invalid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4) against a decimal model.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .invalid   (invalid)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (plain decimal arithmetic) -------------
    function automatic longint from_bcd(input logic [W-1:0] v);
        longint r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint n);
        logic [W-1:0] r = '0;
        longint m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         input logic mc, output logic [W-1:0] es, output logic ec);
        longint modv = 1;
        longint r;
        for (int i = 0; i < DIGITS; i++) modv = modv * 10;
        if (ms) begin
            r  = from_bcd(ma) - from_bcd(mb) - longint'(mc);
            ec = (r >= 0);
            if (r < 0) r = r + modv;
        end else begin
            r  = from_bcd(ma) + from_bcd(mb) + longint'(mc);
            ec = (r >= modv);
            r  = r % modv;
        end
        es = to_bcd(r);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(9));
        return r;
    endfunction

    // ---------------- handshake drivers ---------------------------------------
    // Offers an operand set and returns #1 after the accepting edge, with the
    // inputs scrambled so that post-accept changes are exercised.
    task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb,
                          input logic ls, input logic lc);
        int g = 0;
        @(negedge clk);
        a = la; b = lb; sub = ls; cin = lc; in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    endtask

    // Counts edges from the accepting edge (which is edge 1) to out_valid.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        nvec++; if (sum !== '0) begin nerr++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        nvec++; if (cout !== 1'b0 || invalid !== 1'b0) begin nerr++; $display("FAIL reset_flags cout=%b invalid=%b exp=0/0", cout, invalid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{16'h1234, 16'h9999, 16'h5000, 16'h0000};
        logic [W-1:0] vb [4] = '{16'h5678, 16'h0001, 16'h1234, 16'h0001};
        logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] es [4] = '{16'h6912, 16'h0000, 16'h3766, 16'h9999};
        logic         ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            launch(va[i], vb[i], vs[i], 1'b0);
            wait_done(lat);
            nvec++; if (lat != DIGITS + 1) begin nerr++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, DIGITS + 1); end
            nvec++; if (sum !== es[i] || cout !== ec[i]) begin
                nerr++; $display("FAIL dir%0d_result got=%h/%b exp=%h/%b", i, sum, cout, es[i], ec[i]);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, es;
        logic         rs, rc, ec;
        int           lat, d;
        for (int i = 0; i < 30; i++) begin
            ra = rand_bcd(); rb = rand_bcd();
            rs = 1'($urandom); rc = 1'($urandom);
            model(ra, rb, rs, rc, es, ec);
            launch(ra, rb, rs, rc);
            wait_done(lat);
            d = $urandom_range(3);
            repeat (d) @(posedge clk);
            #1;
            nvec++; if (lat != DIGITS + 1 || out_valid !== 1'b1 || sum !== es || cout !== ec || invalid !== 1'b0) begin
                nerr++;
                $display("FAIL rand%0d a=%h b=%h sub=%b cin=%b got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                         i, ra, rb, rs, rc, sum, cout, lat, es, ec, DIGITS + 1);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        launch(16'h2468, 16'h1357, 1'b0, 1'b1);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = rand_bcd(); b = rand_bcd();
            #1;
            nvec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h3826 || cout !== 1'b0) begin
                nerr++;
                $display("FAIL hold%0d got ov=%b ir=%b sum=%h cout=%b exp ov=1 ir=0 sum=3826 cout=0",
                         i, out_valid, in_ready, sum, cout);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL after_consume got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(16'h0999, 16'h0001, 1'b0, 1'b0);
        wait_done(lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h0042; b = 16'h0050; sub = 1'b1; cin = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_ready_in_done got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL b2b_idle got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        // 0042 - 0050 - 1 = -9 -> 9991 with borrow
        nvec++; if (lat != DIGITS + 1 || sum !== 16'h9991 || cout !== 1'b0) begin
            nerr++; $display("FAIL b2b_second got=%h/%b lat=%0d exp=9991/0 lat=%0d", sum, cout, lat, DIGITS + 1);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        launch(16'h4321, 16'h1111, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL rstmid_in_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        nvec++; if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            nerr++; $display("FAIL rstmid_state got ov=%b sum=%h cout=%b exp 0/0000/0", out_valid, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        launch(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_done(lat);
        nvec++; if (lat != DIGITS + 1 || sum !== 16'h0002 || cout !== 1'b0) begin
            nerr++; $display("FAIL rstmid_next got=%h/%b lat=%0d exp=0002/0 lat=%0d", sum, cout, lat, DIGITS + 1);
        end
        consume();
    endtask

    task automatic test_invalid();
        int   lat;
        logic exp_inv;
`ifdef BCD_INVALID_DETECT_EN
        exp_inv = 1'b1;
`else
        exp_inv = 1'b0;
`endif
        launch(16'h00A0, 16'h0000, 1'b0, 1'b0);
        wait_done(lat);
        nvec++; if (lat != DIGITS + 1 || invalid !== exp_inv) begin
            nerr++; $display("FAIL invalid_flag got=%b lat=%0d exp=%b", invalid, lat, exp_inv);
        end
        consume();
        launch(16'h0123, 16'h0456, 1'b0, 1'b0);
        wait_done(lat);
        nvec++; if (invalid !== 1'b0 || sum !== 16'h0579) begin
            nerr++; $display("FAIL invalid_clear got inv=%b sum=%h exp inv=0 sum=0579", invalid, sum);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_invalid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, operand set offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand set.
REQ-006 SHALL have ports a and b, inputs, 4*DIGITS each, packed BCD operands; digit 0 in bits [3:0] and is the least significant digit (LSD).
REQ-007 SHALL have port sub, input, 1, mode select: 0 = add, 1 = subtract (a - b).
REQ-008 SHALL have port cin, input, 1, carry-in in add mode, borrow-in in subtract mode.
REQ-009 SHALL have port out_valid, output, 1, result held.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port sum, output, 4*DIGITS, packed BCD result.
REQ-012 SHALL have port cout, output, 1, add: decimal carry-out; subtract: 1 = no borrow (result non-negative), 0 = borrow (sum is ten's complement).
REQ-013 SHALL have port invalid, output, 1, non-BCD input digit flag (see Configuration).

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-015 SHALL drive in_ready=1 only in IDLE; accept occurs on in_valid && in_ready, capturing a, b, sub, cin into registers and entering BUSY with digit index 0.
REQ-016 SHALL ignore changes on a, b, sub, cin after accept.
REQ-017 SHALL process exactly one digit per BUSY cycle, LSD first, chaining the digit carry through a 1-bit carry register.
REQ-018 SHALL form each digit as t = a_i + b'_i + c (5-bit), where b'_i = b_i (add) or 9 - b_i (subtract); initial c = cin (add) or !cin (subtract).
REQ-019 SHALL output digit t-10 with carry 1 when t > 9, else t[3:0] with carry 0.
REQ-020 SHALL leave BUSY after the digit DIGITS-1 cycle, entering DONE with out_valid=1; accept-to-out_valid latency is exactly DIGITS+1 clock edges.
REQ-021 SHALL hold sum, cout, invalid and out_valid stable in DONE until out_valid && out_ready; then return to IDLE (in_ready=1 the next cycle).
REQ-022 SHALL not accept a new operand in the same cycle a result is consumed; throughput is one operation per DIGITS+2 cycles minimum.
REQ-023 SHALL, with DIGITS=1, behave as a single-digit BCD adder/subtractor with the same handshake.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, force state IDLE, out_valid=0, sum=0, cout=0, invalid=0, carry and digit index to 0; in_ready SHALL be 0 during the reset cycle.
REQ-025 SHALL abort any operation in BUSY or DONE on rst with no result delivered; rst has priority over in_valid and out_ready.

Configuration
REQ-026 SHALL compile the invalid-digit checker only when macro BCD_INVALID_DETECT_EN is defined.
REQ-027 With BCD_INVALID_DETECT_EN defined, invalid SHALL be set in DONE if any captured digit of a or b exceeds 9; sum/cout are then unspecified.
REQ-028 Without BCD_INVALID_DETECT_EN, invalid SHALL be constant 0 and the port SHALL remain present.

Structure
REQ-029 SHALL place in shared package bcd_pkg: BCD_DIGIT_W=4 constant, digit typedef, FSM state enum, nines-complement function.
REQ-030 SHALL instantiate one combinational sub-module bcd_digit_step (4-bit a, 4-bit b, carry-in -> 4-bit digit, carry-out) for the per-digit operation.

Verification (DIGITS=4)
REQ-031 Add: a=1234, b=5678, cin=0 -> sum=6912, cout=0, out_valid exactly 5 edges after accept.
REQ-032 Add wrap: a=9999, b=0001, cin=0 -> sum=0000, cout=1.
REQ-033 Subtract: a=5000, b=1234, cin=0 -> sum=3766, cout=1; a=0000, b=0001 -> sum=9999, cout=0.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/out_valid unchanged, in_ready=0 throughout; new in_valid ignored.
REQ-035 Reset mid-BUSY (after 2 digits) -> next cycle state IDLE, out_valid=0, sum=0; following operation 0001+0001 -> 0002.
REQ-036 With BCD_INVALID_DETECT_EN: a=0x00A0 -> invalid=1; without the macro -> invalid=0.
